// File: rtl/simd_instr_receiver_pkg.sv
// simd_instr_receiver_pkg: instruction word format, opcodes, receiver states and INFO field layout
// shared between the issuer and the SIMD instruction receiver.
package simd_instr_receiver_pkg;

    localparam int P_ADDR_W = 16;
    localparam int P_CNT_W  = 8;
    localparam int P_OP_W   = 4;

    localparam logic [1:0] INSTR_NOP   = 2'd0;
    localparam logic [1:0] INSTR_LD    = 2'd1;
    localparam logic [1:0] INSTR_INFO  = 2'd2;
    localparam logic [1:0] INSTR_STORE = 2'd3;

    typedef struct packed {
        logic [1:0]          opcode;
        logic [P_ADDR_W-1:0] payload;
    } instr_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_CAPT, RX_LOAD_A, RX_LOAD_B, RX_EXEC, RX_STORE, RX_FINISH
    } rx_state_e;

    // INFO payload is {count, op, zero pad}, count in the MSBs
    localparam int INFO_CNT_LSB = P_ADDR_W - P_CNT_W;
    localparam int INFO_OP_LSB  = INFO_CNT_LSB - P_OP_W;

    function automatic logic [1:0] expected_opcode(input logic [1:0] idx);
        return idx == 2'd2 ? INSTR_INFO : idx == 2'd3 ? INSTR_STORE : INSTR_LD;
    endfunction

endpackage

// File: rtl/simd_instr_receiver_if.sv
// simd_instr_receiver_if: issuer <-> processor handshake (enable, ack, instruction word, busy, finish).
interface simd_instr_receiver_if;

    logic                            en;
    logic                            ack;
    simd_instr_receiver_pkg::instr_t instr;
    logic                            busy;
    logic                            finish;

    modport master (output en, ack, instr, input busy, finish);
    modport slave  (input en, ack, instr, output busy, finish);

endinterface

// File: rtl/simd_instr_receiver_word_capture.sv
// instr_word_capture: 4-entry instruction payload bank filled in order on each ack, with an
// optional opcode-order check enabled by PROC_PROTO_CHECK_EN.
module instr_word_capture
    import simd_instr_receiver_pkg::*;
#(
    parameter int ADDR_W = P_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_capt,
    input  instr_t            i_instr,
    output logic [ADDR_W-1:0] o_words [4],
`ifdef PROC_PROTO_CHECK_EN
    output logic              o_mismatch,
`endif
    output logic              o_last
);

    logic [1:0]        r_idx;
    logic [ADDR_W-1:0] r_words [4];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx <= '0;
            for (int k = 0; k < 4; k++) r_words[k] <= '0;
        end else if (i_start) begin
            r_idx <= '0;
        end else if (i_capt) begin
            r_words[r_idx] <= i_instr.payload[ADDR_W-1:0];
            r_idx          <= r_idx + 2'd1;
        end
    end

    assign o_words = r_words;
    assign o_last  = i_capt && r_idx == 2'd3;

`ifdef PROC_PROTO_CHECK_EN
    assign o_mismatch = i_capt && i_instr.opcode != expected_opcode(r_idx);
`else
    logic w_unused;
    assign w_unused = ^i_instr.opcode;
`endif

endmodule

// File: rtl/simd_instr_receiver.sv
// simd_instr_receiver: captures LD/LD/INFO/STORE words from the issuer and sequences load, execute
// and store requests; define PROC_PROTO_CHECK_EN for the sticky protocol error flag o_err.
module simd_instr_receiver
    import simd_instr_receiver_pkg::*;
#(
    parameter int ADDR_W = P_ADDR_W,
    parameter int CNT_W  = P_CNT_W,
    parameter int OP_W   = P_OP_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    simd_instr_receiver_if.slave iss,
    output logic                 o_ld_req,
    output logic [ADDR_W-1:0]    o_ld_addr,
    output logic                 o_ld_slot,
    input  logic                 i_ld_done,
    output logic                 o_exec_start,
    output logic [OP_W-1:0]      o_exec_op,
    output logic [CNT_W-1:0]     o_exec_count,
    input  logic                 i_exec_done,
    output logic                 o_st_req,
    output logic [ADDR_W-1:0]    o_st_addr,
    input  logic                 i_st_done,
    output logic                 o_err
);

    localparam logic [2:0] S_IDLE   = RX_IDLE;
    localparam logic [2:0] S_CAPT   = RX_CAPT;
    localparam logic [2:0] S_LOAD_A = RX_LOAD_A;
    localparam logic [2:0] S_LOAD_B = RX_LOAD_B;
    localparam logic [2:0] S_EXEC   = RX_EXEC;
    localparam logic [2:0] S_STORE  = RX_STORE;
    localparam logic [2:0] S_FINISH = RX_FINISH;

    logic [2:0]        r_state, w_next;
    logic              r_busy, r_exec_first;
    logic [ADDR_W-1:0] w_words [4];
    logic              w_last, w_start, w_capt;
    logic [CNT_W-1:0]  w_count;
    logic [OP_W-1:0]   w_op;
    logic              w_unused;

    assign w_start  = iss.en && r_state == S_IDLE;
    assign w_capt   = iss.ack && r_state == S_CAPT;
    assign w_count  = w_words[2][ADDR_W-1 -: CNT_W];
    assign w_op     = w_words[2][ADDR_W-CNT_W-1 -: OP_W];
    assign w_unused = ^w_words[2];

`ifdef PROC_PROTO_CHECK_EN
    logic w_mismatch, r_err;

    instr_word_capture #(.ADDR_W(ADDR_W)) u_capture (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(w_start), .i_capt(w_capt), .i_instr(iss.instr),
        .o_words(w_words), .o_mismatch(w_mismatch), .o_last(w_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_err <= 1'b0;
        else       r_err <= r_err | w_mismatch | (iss.en && r_state != S_IDLE);
    end

    assign o_err = r_err;
`else
    instr_word_capture #(.ADDR_W(ADDR_W)) u_capture (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(w_start), .i_capt(w_capt), .i_instr(iss.instr),
        .o_words(w_words), .o_last(w_last)
    );

    assign o_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = iss.en ? S_CAPT : S_IDLE;
            S_CAPT:   w_next = w_last ? S_LOAD_A : S_CAPT;
            S_LOAD_A: w_next = i_ld_done ? S_LOAD_B : S_LOAD_A;
            S_LOAD_B: w_next = !i_ld_done ? S_LOAD_B : w_count == '0 ? S_STORE : S_EXEC;
            S_EXEC:   w_next = i_exec_done ? S_STORE : S_EXEC;
            S_STORE:  w_next = i_st_done ? S_FINISH : S_STORE;
            S_FINISH: w_next = iss.ack ? S_IDLE : S_FINISH;
            default:  w_next = S_IDLE;
        endcase
    end

    // busy and the execute pulse are registered from the next state so they line up with it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_exec_first <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_busy       <= w_next != S_IDLE;
            r_exec_first <= w_next == S_EXEC && r_state != S_EXEC;
        end
    end

    assign iss.busy     = r_busy;
    assign iss.finish   = r_state == S_FINISH;
    assign o_ld_req     = r_state == S_LOAD_A || r_state == S_LOAD_B;
    assign o_ld_slot    = r_state == S_LOAD_B;
    assign o_ld_addr    = r_state == S_LOAD_A ? w_words[0] : r_state == S_LOAD_B ? w_words[1] : '0;
    assign o_exec_start = r_exec_first;
    assign o_exec_op    = r_state == S_EXEC ? w_op : '0;
    assign o_exec_count = r_state == S_EXEC ? w_count : '0;
    assign o_st_req     = r_state == S_STORE;
    assign o_st_addr    = r_state == S_STORE ? w_words[3] : '0;

endmodule

// File: tb/tb_simd_instr_receiver.sv
// tb_simd_instr_receiver: directed and randomized commands checked cycle by cycle against a
// phase timeline computed from the handshake rules.
module tb_simd_instr_receiver;
    import simd_instr_receiver_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic ld_req, ld_slot, ld_done, exec_start, exec_done, st_req, st_done, err;
    logic [15:0] ld_addr, st_addr;
    logic [3:0]  exec_op;
    logic [7:0]  exec_count;

    int checks = 0;
    int failures = 0;
    logic err_model = 1'b0;

    logic [15:0] c_a, c_b, c_s;
    logic [3:0]  c_op;
    logic [7:0]  c_cnt;
    int c_bad, c_da, c_db, c_de, c_ds, c_df, c_en_at, c_rst_lb;
    int c_ack [4];

    always #5 clk = ~clk;

    simd_instr_receiver_if iss();

    simd_instr_receiver dut (
        .i_clk(clk), .i_rst(rst), .iss(iss),
        .o_ld_req(ld_req), .o_ld_addr(ld_addr), .o_ld_slot(ld_slot), .i_ld_done(ld_done),
        .o_exec_start(exec_start), .o_exec_op(exec_op), .o_exec_count(exec_count),
        .i_exec_done(exec_done), .o_st_req(st_req), .o_st_addr(st_addr), .i_st_done(st_done),
        .o_err(err)
    );

    function automatic logic [63:0] outs();
        return {13'd0, iss.busy, iss.finish, ld_req, ld_slot, ld_addr, exec_start, exec_op,
                exec_count, st_req, st_addr, err};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        iss.en = 1'b0; iss.ack = 1'b0; iss.instr = '0;
        ld_done = 1'b0; exec_done = 1'b0; st_done = 1'b0;
    endtask

    task automatic nominal();
        c_a = 16'h0100; c_b = 16'h0200; c_op = 4'd3; c_cnt = 8'd8; c_s = 16'h0300;
        c_bad = -1; c_ack = '{1, 2, 3, 4};
        c_da = 0; c_db = 0; c_de = 0; c_ds = 0; c_df = 0; c_en_at = 0; c_rst_lb = 0;
    endtask

    // One command: the spec's phase durations give each phase's start cycle relative to the
    // enable cycle (t=0); every cycle the whole output vector is compared with that timeline.
    task automatic run_cmd(input string tag);
        instr_t w [4];
        int tA, tB, tE, tS, tF, tEnd, ec, en_at, k;
        logic eb, ef, el, esl, exs, esr, ee;
        logic [15:0] ela, esa;
        logic [3:0]  eop;
        logic [7:0]  ecn;
        w[0] = {INSTR_LD, c_a};
        w[1] = {INSTR_LD, c_b};
        w[2] = {INSTR_INFO, c_cnt, c_op, 4'h0};
        w[3] = {INSTR_STORE, c_s};
        if (c_bad >= 0) w[c_bad].opcode = w[c_bad].opcode ^ 2'b01;
        tA = c_ack[3] + 1;
        tB = tA + c_da + 1;
        tE = tB + c_db + 1;
        tS = tE + (c_cnt != 0 ? c_de + 1 : 0);
        tF = tS + c_ds + 1;
        tEnd = tF + c_df;
        en_at = c_en_at == -1 ? int'($urandom_range(1, tEnd)) : c_en_at == -2 ? tE : c_en_at;
        ec = 1 << 30;
`ifdef PROC_PROTO_CHECK_EN
        if (c_bad >= 0) ec = c_ack[c_bad];
        if (en_at > 0 && en_at < ec) ec = en_at;
`endif
        k = 0;
        for (int t = 0; t <= tEnd + 1; t++) begin
            @(negedge clk);
            eb  = t >= 1 && t <= tEnd;
            ef  = t >= tF && t <= tEnd;
            el  = t >= tA && t < tE;
            esl = el && t >= tB;
            ela = !el ? 16'h0 : t < tB ? c_a : c_b;
            exs = c_cnt != 0 && t == tE;
            eop = t >= tE && t < tS ? c_op : 4'h0;
            ecn = t >= tE && t < tS ? c_cnt : 8'h0;
            esr = t >= tS && t < tF;
            esa = esr ? c_s : 16'h0;
            ee  = err_model | (t > ec);
            chk($sformatf("%s t=%0d", tag, t), outs(),
                {13'd0, eb, ef, el, esl, ela, exs, eop, ecn, esr, esa, ee});
            if (c_rst_lb != 0 && t == tB) begin
                rst = 1'b1;
                #1;
                chk({tag, " async_reset"}, outs(), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                clear_inputs();
                err_model = 1'b0;
                return;
            end
            iss.en = t == 0 || t == en_at;
            if (k < 4 && t == c_ack[k]) begin
                iss.ack = 1'b1;
                iss.instr = w[k];
                k++;
            end else begin
                iss.instr = instr_t'($urandom);
                iss.ack = t >= tF ? (t >= tEnd) : (t > c_ack[3]) ? 1'($urandom) : 1'b0;
            end
            ld_done   = t == tA + c_da || t == tB + c_db || ((t < tA || t >= tE) && 1'($urandom));
            exec_done = (c_cnt != 0 && t == tE + c_de) || ((t < tE || t >= tS) && 1'($urandom));
            st_done   = t == tS + c_ds || ((t < tS || t >= tF) && 1'($urandom));
        end
        if (ec < (1 << 30)) err_model = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("reset_state", outs(), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ack_ignored", outs(), 64'd0);
            iss.ack = 1'($urandom);
            iss.instr = instr_t'($urandom);
        end
        @(negedge clk);
        clear_inputs();

        nominal();
        run_cmd("nominal");

        nominal();
        c_ack = '{1, 3, 4, 7};
        run_cmd("ack_gaps");

        nominal();
        c_cnt = 8'd0;
        run_cmd("count_zero");

        nominal();
        c_da = 2; c_db = 1; c_de = 3; c_ds = 2; c_df = 2;
        run_cmd("slow_done");

        for (int n = 0; n < 25; n++) begin
            int g;
            c_a = 16'($urandom); c_b = 16'($urandom); c_s = 16'($urandom);
            c_op = 4'($urandom);
            c_cnt = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom);
            c_bad = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 3)) : -1;
            g = 0;
            for (int i = 0; i < 4; i++) begin
                g += int'($urandom_range(1, 3));
                c_ack[i] = g;
            end
            c_da = $urandom_range(0, 3); c_db = $urandom_range(0, 3);
            c_de = $urandom_range(0, 3); c_ds = $urandom_range(0, 3);
            c_df = $urandom_range(0, 2);
            c_en_at = $urandom_range(0, 4) == 0 ? -1 : 0;
            c_rst_lb = 0;
            run_cmd($sformatf("random%0d", n));
        end

        nominal();
        c_bad = 2;
        run_cmd("bad_info_opcode");

        nominal();
        c_en_at = -2;
        run_cmd("en_during_exec");

        nominal();
        c_rst_lb = 1;
        run_cmd("reset_in_load_b");

        nominal();
        c_a = 16'h1234; c_b = 16'h5678; c_op = 4'hA; c_cnt = 8'h05; c_s = 16'h9ABC;
        run_cmd("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
